// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART controller: register map, STATUS/CTRL
// bit positions and the TX sequencer state encoding.
package uart_pkg;

    localparam logic [7:0] ADDR_TXDATA  = 8'h00;
    localparam logic [7:0] ADDR_RXDATA  = 8'h01;
    localparam logic [7:0] ADDR_STATUS  = 8'h02;
    localparam logic [7:0] ADDR_CTRL    = 8'h03;
    localparam logic [7:0] ADDR_BAUDDIV = 8'h04;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_TX_BUSY    = 2;
    localparam int ST_RX_VALID   = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_TX_DROP    = 5;

    localparam int CTRL_TX_EN      = 0;
    localparam int CTRL_IRQ_RX_EN  = 1;
    localparam int CTRL_IRQ_TXE_EN = 2;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the transmit path; pointers carry one extra wrap bit so
// full and empty are distinguishable without a separate counter.
module uart_tx_fifo #(
    parameter int TX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] dout
);

    localparam int AW = $clog2(TX_DEPTH);

    logic [7:0]  mem [TX_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // The caller only pushes when there is room (or a pop frees a slot this
    // cycle) and only pops when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_apb_ctrl.sv
// APB register front-end for a UART: TX FIFO plus launch sequencer, RX holding
// register, sticky error flags, control/baud registers and a level interrupt.
module uart_apb_ctrl
    import uart_pkg::*;
#(
    parameter int         TX_DEPTH = 4,
    parameter logic [7:0] DIV_RST  = 8'd16
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       rx_done,
    input  logic [7:0] rx_data,
    output logic [7:0] baud_div,
    output logic       irq
);

    // Bus handshake: an access is the single cycle with PSEL & PENABLE high;
    // PREADY is always 1, so every side effect happens exactly in that cycle.
    logic wr_acc, rd_acc, addr_mapped;
    logic wr_tx, wr_ctrl, wr_baud, wr_status, rd_rx;

    assign wr_acc      = PSEL & PENABLE & PWRITE;
    assign rd_acc      = PSEL & PENABLE & ~PWRITE;
    assign addr_mapped = (PADDR <= ADDR_BAUDDIV);
    assign wr_tx       = wr_acc & (PADDR == ADDR_TXDATA);
    assign wr_ctrl     = wr_acc & (PADDR == ADDR_CTRL);
    assign wr_baud     = wr_acc & (PADDR == ADDR_BAUDDIV);
    assign wr_status   = wr_acc & (PADDR == ADDR_STATUS);
    assign rd_rx       = rd_acc & (PADDR == ADDR_RXDATA);

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & ~addr_mapped;

    tx_state_t  tx_state, tx_state_nxt;
    logic [2:0] ctrl_q;
    logic [7:0] baud_q, rx_hold, tx_data_q, status;
    logic       rx_valid, rx_overrun, tx_drop, tx_busy;
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_dout;
    logic       ovr_set, drop_set;

    assign tx_busy   = (tx_state != TX_IDLE);
    assign fifo_pop  = (tx_state == TX_LOAD);
    assign fifo_push = wr_tx & (~fifo_full | fifo_pop);
    assign drop_set  = wr_tx & fifo_full & ~fifo_pop;
    // A read in the same cycle consumes the old byte, so that is not an overrun.
    assign ovr_set   = rx_done & rx_valid & ~rd_rx;

    uart_tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (PWDATA),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) tx_state <= TX_IDLE;
        else          tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_start     = 1'b0;
        case (tx_state)
            TX_IDLE: if (ctrl_q[CTRL_TX_EN] && !fifo_empty) tx_state_nxt = TX_LOAD;
            TX_LOAD: begin
                tx_start     = 1'b1;
                tx_state_nxt = TX_BUSY;
            end
            TX_BUSY: if (tx_done) tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // The head byte is presented during LOAD and held from then until the next launch.
    assign tx_data = (tx_state == TX_LOAD) ? fifo_dout : tx_data_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tx_data_q  <= 8'h00;
            ctrl_q     <= 3'b000;
            baud_q     <= DIV_RST;
            rx_hold    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            tx_drop    <= 1'b0;
        end else begin
            if (fifo_pop) tx_data_q <= fifo_dout;
            if (wr_ctrl)  ctrl_q    <= PWDATA[2:0];
            if (wr_baud)  baud_q    <= PWDATA;
            if (rx_done) begin
                rx_hold  <= rx_data;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            if (ovr_set)                                   rx_overrun <= 1'b1;
            else if (wr_status && PWDATA[ST_RX_OVERRUN])   rx_overrun <= 1'b0;
            if (drop_set)                                  tx_drop    <= 1'b1;
            else if (wr_status && PWDATA[ST_TX_DROP])      tx_drop    <= 1'b0;
        end
    end

    always_comb begin
        status                = 8'h00;
        status[ST_TX_FULL]    = fifo_full;
        status[ST_TX_EMPTY]   = fifo_empty;
        status[ST_TX_BUSY]    = tx_busy;
        status[ST_RX_VALID]   = rx_valid;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_TX_DROP]    = tx_drop;
    end

    always_comb begin
        PRDATA = 8'h00;
        if (rd_acc) begin
            case (PADDR)
                ADDR_RXDATA:  PRDATA = rx_hold;
                ADDR_STATUS:  PRDATA = status;
                ADDR_CTRL:    PRDATA = {5'b00000, ctrl_q};
                ADDR_BAUDDIV: PRDATA = baud_q;
                default:      PRDATA = 8'h00;
            endcase
        end
    end

    assign baud_div = baud_q;
    assign irq = (ctrl_q[CTRL_IRQ_RX_EN] & rx_valid) |
                 (ctrl_q[CTRL_IRQ_TXE_EN] & fifo_empty & ~tx_busy);

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// Bench for uart_apb_ctrl: a register-level model checked every cycle on the
// falling edge, plus directed scenarios with literal expectations.
module tb_uart_apb_ctrl;

    localparam int DEPTH = 4;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0] PADDR = 8'h00, PWDATA = 8'h00;
    logic [7:0] PRDATA;
    logic       PREADY, PSLVERR;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] baud_div;
    logic       irq;

    always #5 PCLK = ~PCLK;

    uart_apb_ctrl #(.TX_DEPTH(DEPTH), .DIV_RST(8'd16)) dut (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .rx_done  (rx_done),
        .rx_data  (rx_data),
        .baud_div (baud_div),
        .irq      (irq)
    );

    // ---------------- model state (owned by the compare process) ----------------
    logic [7:0] exp_q[$];
    logic       m_busy = 1'b0, m_rxv = 1'b0, m_ovr = 1'b0, m_drop = 1'b0;
    logic [7:0] m_rx = 8'h00, m_baud = 8'h10;
    logic [2:0] m_ctrl = 3'b000;
    int         cyc = 0;
    int         launch_cyc[$];
    logic [7:0] launch_dat[$];
    int         n_chk_m = 0, n_pass_m = 0, n_chk_d = 0, n_pass_d = 0;

    function automatic logic [7:0] m_status();
        return {2'b00, m_drop, m_ovr, m_rxv, m_busy,
                exp_q.size() == 0, exp_q.size() == DEPTH};
    endfunction

    function automatic logic m_irq();
        return (m_ctrl[1] & m_rxv) | (m_ctrl[2] & (exp_q.size() == 0) & ~m_busy);
    endfunction

    task automatic check_m(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk_m++;
        if (act === exp) n_pass_m++;
        else $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic check_d(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk_d++;
        if (act === exp) n_pass_d++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    // Compare process: checks outputs against the model, then advances the
    // model with the inputs that the coming rising edge will sample.
    always @(negedge PCLK) begin
        logic rd, wr, rd_rx, ovr_set, drop_set;
        logic [7:0] exp_rd;
        cyc++;
        if (!PRESETn) begin
            exp_q.delete();
            m_busy = 1'b0; m_rxv = 1'b0; m_ovr = 1'b0; m_drop = 1'b0;
            m_rx = 8'h00; m_baud = 8'h10; m_ctrl = 3'b000;
        end else begin
            rd    = PSEL && PENABLE && !PWRITE;
            wr    = PSEL && PENABLE && PWRITE;
            rd_rx = rd && (PADDR == 8'h01);
            if (tx_start) begin
                launch_cyc.push_back(cyc);
                launch_dat.push_back(tx_data);
                n_chk_m++;
                if (exp_q.size() > 0 && !m_busy && tx_data === exp_q[0]) n_pass_m++;
                else $display("FAIL tx_launch: got %02h expected %02h (queued %0d, busy %0b)",
                              tx_data, (exp_q.size() > 0) ? exp_q[0] : 8'h00, exp_q.size(), m_busy);
                m_busy = 1'b1;
            end
            check_m("baud_div", baud_div, m_baud);
            check_m("irq", {7'd0, irq}, {7'd0, m_irq()});
            check_m("pready", {7'd0, PREADY}, 8'h01);
            check_m("pslverr", {7'd0, PSLVERR}, {7'd0, PSEL && PENABLE && (PADDR > 8'h04)});
            exp_rd = 8'h00;
            if (rd) begin
                case (PADDR)
                    8'h01: exp_rd = m_rx;
                    8'h02: exp_rd = m_status();
                    8'h03: exp_rd = {5'd0, m_ctrl};
                    8'h04: exp_rd = m_baud;
                    default: exp_rd = 8'h00;
                endcase
            end
            if (!(rd && PADDR == 8'h00)) check_m("prdata", PRDATA, exp_rd);

            // next state
            ovr_set = 1'b0;
            drop_set = 1'b0;
            if (tx_start) void'(exp_q.pop_front());
            else if (tx_done) m_busy = 1'b0;
            if (wr) begin
                case (PADDR)
                    8'h00: if (exp_q.size() < DEPTH) exp_q.push_back(PWDATA); else drop_set = 1'b1;
                    8'h03: m_ctrl = PWDATA[2:0];
                    8'h04: m_baud = PWDATA;
                    default: ;
                endcase
            end
            if (rx_done) begin
                if (m_rxv && !rd_rx) ovr_set = 1'b1;
                m_rx  = rx_data;
                m_rxv = 1'b1;
            end else if (rd_rx) begin
                m_rxv = 1'b0;
            end
            if (ovr_set) m_ovr = 1'b1;
            else if (wr && PADDR == 8'h02 && PWDATA[4]) m_ovr = 1'b0;
            if (drop_set) m_drop = 1'b1;
            else if (wr && PADDR == 8'h02 && PWDATA[5]) m_drop = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb(input logic w, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic rxp, input logic [7:0] rxd,
                       output logic [7:0] rdata, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = addr; PWDATA = wdata;
        tick();
        PENABLE = 1'b1;
        rx_done = rxp;
        rx_data = rxd;
        #2;
        rdata = PRDATA;
        err   = PSLVERR;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; rx_done = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] d;
        logic e;
        apb(1'b1, addr, data, 1'b0, 8'h00, d, e);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        logic e;
        apb(1'b0, addr, 8'h00, 1'b0, 8'h00, d, e);
        check_d(name, d, exp);
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rx_data = d;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic wait_launch(input int n, input string name);
        int t = 0;
        while (launch_dat.size() < n && t < 40) begin
            tick();
            t++;
        end
        check_d(name, 8'(launch_dat.size()), 8'(n));
    endtask

    task automatic frame_done(output int done_id);
        tick();
        tick();
        done_id = cyc + 1;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [7:0] d;
        logic e;
        int done_id, base;
        logic [7:0] t2_exp[5];
        t2_exp = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h26};

        repeat (3) tick();
        check_d("rst_tx_start", {7'd0, tx_start}, 8'h00);
        check_d("rst_tx_data", tx_data, 8'h00);
        check_d("rst_irq", {7'd0, irq}, 8'h00);
        PRESETn = 1'b1;
        tick();
        apb(1'b0, 8'h04, 8'h00, 1'b0, 8'h00, d, e);
        check_d("rst_bauddiv", d, 8'h10);
        check_d("rst_pslverr", {7'd0, e}, 8'h00);
        rd_chk("rst_status", 8'h02, 8'h02);

        // two bytes back to back; second launch two cycles after first tx_done
        wr(8'h03, 8'h01);
        wr(8'h00, 8'hA5);
        wr(8'h00, 8'h3C);
        wait_launch(1, "t1_launch1");
        check_d("t1_data1", launch_dat[0], 8'hA5);
        tick();
        check_d("t1_data_hold", tx_data, 8'hA5);
        frame_done(done_id);
        wait_launch(2, "t1_launch2");
        check_d("t1_data2", launch_dat[1], 8'h3C);
        check_d("t1_gap", 8'(launch_cyc[1] - done_id), 8'd2);
        frame_done(done_id);
        tick();
        rd_chk("t1_status_idle", 8'h02, 8'h02);

        // fill while a frame is in flight with tx_en cleared
        wr(8'h00, 8'h10);
        wr(8'h03, 8'h00);
        wait_launch(3, "t2_launch_first");
        for (int i = 0; i < 5; i++) wr(8'h00, 8'h21 + 8'(i));
        rd_chk("t2_status_full_drop", 8'h02, 8'h25);
        frame_done(done_id);
        tick();
        rd_chk("t2_status_no_launch", 8'h02, 8'h21);
        wr(8'h02, 8'h20);
        rd_chk("t2_drop_cleared", 8'h02, 8'h01);
        wr(8'h03, 8'h01);
        wr(8'h00, 8'h26);
        rd_chk("t2_push_pop_full", 8'h02, 8'h05);
        for (int i = 0; i < 5; i++) begin
            wait_launch(4 + i, "t2_launch");
            check_d("t2_order", launch_dat[3 + i], t2_exp[i]);
            frame_done(done_id);
        end
        tick();
        rd_chk("t2_status_drained", 8'h02, 8'h02);

        // RX overrun and W1C
        wr(8'h03, 8'h02);
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        check_d("t3_irq_rx", {7'd0, irq}, 8'h01);
        rd_chk("t3_status_ovr", 8'h02, 8'h1A);
        rd_chk("t3_rxdata", 8'h01, 8'h22);
        check_d("t3_irq_clear", {7'd0, irq}, 8'h00);
        rd_chk("t3_status_after_rd", 8'h02, 8'h12);
        wr(8'h02, 8'h10);
        rd_chk("t3_ovr_cleared", 8'h02, 8'h02);
        rx_pulse(8'h66);
        apb(1'b1, 8'h02, 8'h10, 1'b1, 8'h77, d, e);
        rd_chk("t3_set_beats_clear", 8'h02, 8'h1A);
        rd_chk("t3_rxdata_77", 8'h01, 8'h77);
        wr(8'h02, 8'h10);

        // rx_done coincident with RXDATA read
        rx_pulse(8'h44);
        apb(1'b0, 8'h01, 8'h00, 1'b1, 8'h55, d, e);
        check_d("t4_read_old", d, 8'h44);
        rd_chk("t4_status", 8'h02, 8'h0A);
        rd_chk("t4_read_new", 8'h01, 8'h55);
        rd_chk("t4_status_empty", 8'h02, 8'h02);

        // unmapped address, register writes, TX-empty interrupt
        apb(1'b1, 8'h07, 8'hFF, 1'b0, 8'h00, d, e);
        check_d("t5_wr_unmapped_err", {7'd0, e}, 8'h01);
        check_d("t5_wr_unmapped_rd", d, 8'h00);
        apb(1'b0, 8'h07, 8'h00, 1'b0, 8'h00, d, e);
        check_d("t5_rd_unmapped_err", {7'd0, e}, 8'h01);
        check_d("t5_rd_unmapped_rd", d, 8'h00);
        rd_chk("t5_ctrl_kept", 8'h03, 8'h02);
        rd_chk("t5_baud_kept", 8'h04, 8'h10);
        wr(8'h04, 8'h2A);
        check_d("t5_baud_out", baud_div, 8'h2A);
        wr(8'h03, 8'h04);
        check_d("t5_irq_txe", {7'd0, irq}, 8'h01);

        // reset in the middle of a frame
        wr(8'h03, 8'h07);
        rx_pulse(8'h88);
        base = launch_dat.size();
        wr(8'h00, 8'h99);
        wait_launch(base + 1, "t6_launch");
        tick();
        check_d("t6_busy_data", tx_data, 8'h99);
        check_d("t6_irq_before", {7'd0, irq}, 8'h01);
        #2 PRESETn = 1'b0;
        #1;
        check_d("t6_rst_tx_start", {7'd0, tx_start}, 8'h00);
        check_d("t6_rst_tx_data", tx_data, 8'h00);
        check_d("t6_rst_irq", {7'd0, irq}, 8'h00);
        check_d("t6_rst_baud", baud_div, 8'h10);
        tick();
        PRESETn = 1'b1;
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        repeat (4) tick();
        check_d("t6_stale_done_ignored", 8'(launch_dat.size()), 8'(base + 1));
        rd_chk("t6_status", 8'h02, 8'h02);
        rd_chk("t6_ctrl", 8'h03, 8'h00);
        rd_chk("t6_baud", 8'h04, 8'h10);
        check_d("t6_scoreboard_drained", 8'(exp_q.size()), 8'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass_m + n_pass_d, n_chk_m + n_chk_d);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

endmodule
